// File: rtl/mem_stage.sv
// mem_stage: MIPS memory-access stage; waits for data-SRAM responses, aligns load data
// and drops responses that belong to instructions killed by a flush.
module mem_stage (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         es_to_ms_valid,
    input  logic [167:0] es_to_ms_bus,
    input  logic         es_outstanding,
    output logic         ms_allowin,
    input  logic         data_sram_data_ok,
    input  logic [31:0]  data_sram_rdata,
    input  logic         ws_allowin,
    output logic         ms_to_ws_valid,
    output logic [125:0] ms_to_ws_bus,
    output logic [10:0]  stall_ms_bus,
    output logic [32:0]  forward_ms_bus,
    output logic         ms_exc_eret
);
    logic         ms_valid, data_buf_valid, ms_ready_go, data_ok_acc;
    logic         mem_req, exc, eret, res_from_cp0;
    logic [167:0] bus;
    logic [31:0]  data_buf, d, rt, alu_result, final_result;
    logic [1:0]   discard_cnt, b, cnt_dec, cnt_inc;
    logic [6:0]   load_op;
    logic [3:0]   gr_we, we;
    logic [4:0]   dest, sh;
    logic [7:0]   byte_v;
    logic [15:0]  half;

    assign load_op      = bus[114:108];
    assign mem_req      = bus[107];
    assign b            = bus[106:105];
    assign rt           = bus[104:73];
    assign gr_we        = bus[72:69];
    assign dest         = bus[68:64];
    assign alu_result   = bus[63:32];
    assign exc          = bus[134];
    assign eret         = bus[125];
    assign res_from_cp0 = bus[123];

    // Responses owed to flushed instructions are swallowed before any can complete one.
    assign data_ok_acc    = data_sram_data_ok && discard_cnt == 2'd0 && ms_valid && mem_req && !data_buf_valid;
    assign ms_ready_go    = !mem_req || exc || data_ok_acc || data_buf_valid;
    assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = ms_valid && ms_ready_go;
    assign d              = data_buf_valid ? data_buf : data_sram_rdata;
    assign sh             = {b, 3'b000};
    assign byte_v         = 8'(d >> sh);
    assign half           = b[1] ? d[31:16] : d[15:0];
    assign cnt_dec        = {1'b0, data_sram_data_ok && discard_cnt != 2'd0};
    assign cnt_inc        = flush ? {1'b0, ms_valid && mem_req && !ms_ready_go} + {1'b0, es_outstanding} : 2'd0;

    always_comb begin
        final_result = load_op[6] ? {{24{byte_v[7]}}, byte_v}
                     : load_op[5] ? {24'd0, byte_v}
                     : load_op[4] ? {{16{half[15]}}, half}
                     : load_op[3] ? {16'd0, half}
                     : load_op[2] ? d
                     : load_op[1] ? (d << (5'd24 - sh)) | (rt & (32'h00ffffff >> sh))
                     : load_op[0] ? (d >> sh) | (rt & ~(32'hffffffff >> sh))
                     : alu_result;
        we = load_op[1] ? gr_we & ~(4'b0111 >> b)
           : load_op[0] ? gr_we & (4'b1111 >> b)
           : gr_we;
    end

    assign ms_to_ws_bus   = {bus[167:125], bus[124:115], we, dest, final_result, bus[31:0]};
    assign stall_ms_bus   = {ms_valid && |we, we & {4{ms_valid}}, dest, ms_valid && (res_from_cp0 || !ms_ready_go)};
    assign forward_ms_bus = {ms_valid && ms_ready_go && !res_from_cp0, final_result};
    assign ms_exc_eret    = ms_valid && (exc || eret);

    always_ff @(posedge clk) begin
        if (reset || flush)
            ms_valid <= 1'b0;
        else if (ms_allowin)
            ms_valid <= es_to_ms_valid;
        if (es_to_ms_valid && ms_allowin)
            bus <= es_to_ms_bus;
        if (reset || flush || (ms_to_ws_valid && ws_allowin))
            data_buf_valid <= 1'b0;
        else if (data_ok_acc && !ws_allowin)
            data_buf_valid <= 1'b1;
        if (data_ok_acc && !ws_allowin)
            data_buf <= data_sram_rdata;
        discard_cnt <= reset ? 2'd0 : discard_cnt - cnt_dec + cnt_inc;
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed and randomized checks of mem_stage against a byte-level load model.
module tb_mem_stage;
    logic         clk = 0, reset = 1, flush = 0, es_to_ms_valid = 0, es_outstanding = 0;
    logic         data_sram_data_ok = 0, ws_allowin = 1;
    logic [167:0] es_to_ms_bus = '0;
    logic [31:0]  data_sram_rdata = '0;
    logic         ms_allowin, ms_to_ws_valid, ms_exc_eret;
    logic [125:0] ms_to_ws_bus;
    logic [10:0]  stall_ms_bus;
    logic [32:0]  forward_ms_bus;
    int total = 0, bad = 0;

    mem_stage dut (
        .clk(clk), .reset(reset), .flush(flush), .es_to_ms_valid(es_to_ms_valid),
        .es_to_ms_bus(es_to_ms_bus), .es_outstanding(es_outstanding), .ms_allowin(ms_allowin),
        .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
        .ws_allowin(ws_allowin), .ms_to_ws_valid(ms_to_ws_valid), .ms_to_ws_bus(ms_to_ws_bus),
        .stall_ms_bus(stall_ms_bus), .forward_ms_bus(forward_ms_bus), .ms_exc_eret(ms_exc_eret)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] LB = 7'b1000000, LHU = 7'b0001000, LW = 7'b0000100;
    localparam logic [6:0] LWL = 7'b0000010, LWR = 7'b0000001;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [167:0] mk(input logic [6:0] lop, input logic mreq, input logic [1:0] b,
                                        input logic [31:0] rt, input logic [3:0] we, input logic [4:0] dest,
                                        input logic [31:0] alu, input logic [31:0] pc, input logic exc,
                                        input logic [7:0] et, input logic eret);
        return {alu ^ 32'h5a5a0000, 1'b0, exc, et, eret, 1'b0, 1'b0, 8'd0, lop, mreq, b, rt, we, dest, alu, pc};
    endfunction

    function automatic logic [125:0] xbus(input logic [167:0] i, input logic [31:0] res, input logic [3:0] we);
        return {i[167:136], i[135], i[134], i[133:126], i[125], i[124], i[123], i[122:115], we, i[68:64], res, i[31:0]};
    endfunction

    // Result built byte by byte from the architectural definition of each load.
    function automatic void model(input logic [6:0] lop, input logic [1:0] b, input logic [31:0] rt,
                                  input logic [31:0] d, input logic [31:0] alu, input logic [3:0] we,
                                  output logic [31:0] res, output logic [3:0] wo);
        logic [7:0] db[4], rb[4], ob[4];
        logic [15:0] h;
        int n;
        for (int i = 0; i < 4; i++) begin
            db[i] = d[8*i +: 8];
            rb[i] = rt[8*i +: 8];
        end
        h = {db[{b[1], 1'b1}], db[{b[1], 1'b0}]};
        n = int'(b);
        wo = we;
        res = alu;
        if (lop[6]) res = {{24{db[b][7]}}, db[b]};
        else if (lop[5]) res = {24'd0, db[b]};
        else if (lop[4]) res = {{16{h[15]}}, h};
        else if (lop[3]) res = {16'd0, h};
        else if (lop[2]) res = d;
        else if (lop[1] || lop[0]) begin
            for (int i = 0; i < 4; i++) begin
                if (lop[1]) begin
                    ob[i] = (i >= 3 - n) ? db[(i - 3 + n) & 3] : rb[i];
                    wo[i] = we[i] && (i >= 3 - n);
                end else begin
                    ob[i] = (i <= 3 - n) ? db[(i + n) & 3] : rb[i];
                    wo[i] = we[i] && (i <= 3 - n);
                end
            end
            res = {ob[3], ob[2], ob[1], ob[0]};
        end
    endfunction

    task automatic issue(input logic [167:0] bi);
        @(negedge clk);
        es_to_ms_valid = 1;
        es_to_ms_bus = bi;
        @(posedge clk);
        #1 es_to_ms_valid = 0;
    endtask

    task automatic do_load(input string tag, input logic [167:0] bi, input logic [31:0] rd, input int dly,
                           input int hold, input logic [31:0] xr, input logic [3:0] xw);
        issue(bi);
        repeat (dly) begin
            @(negedge clk);
            #1 chk({tag, ".wait"}, ms_to_ws_valid, 0);
            chk({tag, ".stall"}, stall_ms_bus[0], 1);
        end
        @(negedge clk);
        ws_allowin = (hold == 0);
        data_sram_data_ok = 1;
        data_sram_rdata = rd;
        #1 chk({tag, ".vld"}, ms_to_ws_valid, 1);
        chk({tag, ".bus"}, ms_to_ws_bus, xbus(bi, xr, xw));
        chk({tag, ".fwd"}, forward_ms_bus, {1'b1, xr});
        @(posedge clk);
        #1 data_sram_data_ok = 0;
        data_sram_rdata = $urandom;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            ws_allowin = (i == hold - 1);
            #1 chk({tag, ".hold_vld"}, ms_to_ws_valid, 1);
            chk({tag, ".hold_allowin"}, ms_allowin, ws_allowin);
            chk({tag, ".hold_bus"}, ms_to_ws_bus, xbus(bi, xr, xw));
        end
        if (hold > 0) @(posedge clk);
        #1 ws_allowin = 1;
    endtask

    initial begin
        logic [167:0] bi, n2;
        logic [31:0] rt, rd, alu, xr;
        logic [3:0] xw, we;
        logic [6:0] lop;
        logic [1:0] b;
        int sel;

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 chk("rst.allowin", ms_allowin, 1);
        chk("rst.vld", ms_to_ws_valid, 0);
        chk("rst.exc_eret", ms_exc_eret, 0);
        chk("rst.stall", {stall_ms_bus[10:6], stall_ms_bus[0]}, 0);
        chk("rst.fwd", forward_ms_bus[32], 0);
        reset = 0;

        do_load("lb", mk(LB, 1, 2'd3, 32'h0, 4'hf, 5'd3, 32'h1000, 32'h400, 0, 0, 0),
                32'h80FF1234, 2, 0, 32'hFFFFFF80, 4'hf);
        @(negedge clk);
        #1 chk("lb.gone", ms_to_ws_valid, 0);
        chk("lb.allowin", ms_allowin, 1);

        do_load("lwl", mk(LWL, 1, 2'd1, 32'hAABBCCDD, 4'hf, 5'd4, 32'h2001, 32'h404, 0, 0, 0),
                32'h11223344, 1, 0, 32'h3344CCDD, 4'b1100);
        do_load("lwr", mk(LWR, 1, 2'd1, 32'hAABBCCDD, 4'hf, 5'd5, 32'h2001, 32'h408, 0, 0, 0),
                32'h11223344, 0, 0, 32'hAA112233, 4'b0111);
        do_load("lhu_buf", mk(LHU, 1, 2'd2, 32'h0, 4'hf, 5'd6, 32'h3002, 32'h40c, 0, 0, 0),
                32'h12345678, 1, 3, 32'h00001234, 4'hf);

        // flush with a waiting load and one request still in execute: two responses to drop
        issue(mk(LW, 1, 0, 0, 4'hf, 5'd7, 32'h4000, 32'h500, 0, 0, 0));
        @(negedge clk);
        flush = 1;
        es_outstanding = 1;
        @(posedge clk);
        #1 flush = 0;
        es_outstanding = 0;
        @(negedge clk);
        #1 chk("flush.empty", ms_to_ws_valid, 0);
        chk("flush.allowin", ms_allowin, 1);
        bi = mk(LW, 1, 0, 0, 4'hf, 5'd8, 32'h4004, 32'h504, 0, 0, 0);
        issue(bi);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            data_sram_data_ok = 1;
            data_sram_rdata = 32'hDEAD0000 + k;
            #1 chk("flush.discard", ms_to_ws_valid, 0);
            @(posedge clk);
            #1 data_sram_data_ok = 0;
        end
        @(negedge clk);
        data_sram_data_ok = 1;
        data_sram_rdata = 32'hCAFEF00D;
        #1 chk("flush.third_vld", ms_to_ws_valid, 1);
        chk("flush.third_bus", ms_to_ws_bus, xbus(bi, 32'hCAFEF00D, 4'hf));
        @(posedge clk);
        #1 data_sram_data_ok = 0;

        // an instruction offered during a flush is not taken
        @(negedge clk);
        es_to_ms_valid = 1;
        es_to_ms_bus = mk(0, 0, 0, 0, 4'hf, 5'd9, 32'h77, 32'h600, 0, 0, 0);
        flush = 1;
        @(posedge clk);
        #1 flush = 0;
        es_to_ms_valid = 0;
        @(negedge clk);
        #1 chk("flush.offer_dropped", ms_to_ws_valid, 0);

        bi = mk(0, 0, 0, 0, 4'h0, 5'd0, 32'h0, 32'h700, 1, 8'h04, 0);
        issue(bi);
        @(negedge clk);
        #1 chk("exc.vld", ms_to_ws_valid, 1);
        chk("exc.eret_out", ms_exc_eret, 1);
        chk("exc.fields", {ms_to_ws_bus[92], ms_to_ws_bus[91:84]}, {1'b1, 8'h04});
        chk("exc.bus", ms_to_ws_bus, xbus(bi, 32'h0, 4'h0));

        // back-to-back non-memory instructions
        issue(mk(0, 0, 0, 0, 4'hf, 5'd7, 32'hA1A1A1A1, 32'h800, 0, 0, 0));
        n2 = mk(0, 0, 0, 0, 4'h3, 5'd9, 32'hB2B2B2B2, 32'h804, 0, 0, 0);
        @(negedge clk);
        es_to_ms_valid = 1;
        es_to_ms_bus = n2;
        #1 chk("tp.allowin", ms_allowin, 1);
        chk("tp.pc1", ms_to_ws_bus[31:0], 32'h800);
        chk("tp.fwd", forward_ms_bus, {1'b1, 32'hA1A1A1A1});
        chk("tp.stall", stall_ms_bus, {1'b1, 4'hf, 5'd7, 1'b0});
        @(posedge clk);
        #1 es_to_ms_valid = 0;
        @(negedge clk);
        #1 chk("tp.vld2", ms_to_ws_valid, 1);
        chk("tp.bus2", ms_to_ws_bus, xbus(n2, 32'hB2B2B2B2, 4'h3));

        // reset during a wait with one pending discard
        issue(mk(LW, 1, 0, 0, 4'hf, 5'd1, 32'h10, 32'h900, 0, 0, 0));
        @(negedge clk);
        flush = 1;
        @(posedge clk);
        #1 flush = 0;
        issue(mk(LW, 1, 0, 0, 4'hf, 5'd2, 32'h14, 32'h904, 0, 0, 0));
        @(negedge clk);
        reset = 1;
        @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        #1 chk("rst2.vld", ms_to_ws_valid, 0);
        chk("rst2.allowin", ms_allowin, 1);
        chk("rst2.stall", stall_ms_bus[10], 0);
        do_load("rst2.load", mk(LW, 1, 0, 0, 4'hf, 5'd3, 32'h18, 32'h908, 0, 0, 0),
                32'h5555AAAA, 0, 0, 32'h5555AAAA, 4'hf);

        for (int t = 0; t < 40; t++) begin
            sel = $urandom_range(0, 7);
            lop = (sel == 7) ? 7'd0 : 7'(1 << sel);
            b = 2'($urandom);
            rt = $urandom;
            rd = $urandom;
            alu = $urandom;
            we = 4'($urandom);
            model(lop, b, rt, rd, alu, we, xr, xw);
            do_load("rand", mk(lop, 1, b, rt, we, 5'($urandom), alu, 32'(t * 4), 0, 0, 0),
                    rd, $urandom_range(0, 3), $urandom_range(0, 2), xr, xw);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage MIPS pipeline. It sits between the execute stage and the write-back stage. It holds one instruction and waits for the data-SRAM response when that instruction issued a load or store. It aligns and sign/zero-extends load data, including lwl/lwr merge, and passes a 126-bit bundle to write-back. It also drives hazard, forwarding and exception-cancel information back to decode and execute, and drops stale SRAM responses after a pipeline flush.

## Interface
- No parameters.
- clk  in  1  clock; reset is synchronous and active-high (signal name reset).
- reset  in  1  synchronous, active-high.
- flush  in  1  exception/eret flush from write-back.
- es_to_ms_valid  in  1  execute stage has an instruction for this stage.
- es_to_ms_bus  in  168  fields by bit range:
  - [167:136] badvaddr; [135] bd; [134] exc; [133:126] exc_type; [125] eret.
  - [124] cp0_wen; [123] res_from_cp0; [122:115] cp0_addr.
  - [114:108] load_op, one-hot in order {lb,lbu,lh,lhu,lw,lwl,lwr}, MSB=lb.
  - [107] mem_req, set when execute's SRAM request was accepted; [106:105] addr_low.
  - [104:73] rt_value; [72:69] gr_we; [68:64] dest; [63:32] alu_result; [31:0] pc.
- es_outstanding  in  1  execute holds an instruction whose SRAM request was accepted but not yet answered.
- ms_allowin  out  1  this stage can accept a new instruction.
- data_sram_data_ok  in  1  one-cycle response strobe, in request order.
- data_sram_rdata  in  32  read data, valid with data_ok.
- ws_allowin  in  1  write-back can accept.
- ms_to_ws_valid  out  1.
- ms_to_ws_bus  out  126  fields by bit range:
  - [125:94] badvaddr; [93] bd; [92] exc; [91:84] exc_type; [83] eret.
  - [82] cp0_wen; [81] res_from_cp0; [80:73] cp0_addr; [72:69] gr_we.
  - [68:64] dest; [63:32] final_result; [31:0] pc.
- stall_ms_bus  out  11  fields:
  - bit 10: ms_valid && |gr_we.
  - bits 9:6: gr_we & {4{ms_valid}}.
  - bits 5:1: dest.
  - bit 0: ms_valid && (res_from_cp0 || !ms_ready_go).
- forward_ms_bus  out  33  {ms_valid && ms_ready_go && !res_from_cp0, final_result}.
- ms_exc_eret  out  1  ms_valid && (exc || eret); execute uses it to suppress stores.

## Operation
- Input register: loaded from es_to_ms_bus when es_to_ms_valid && ms_allowin.
- ms_valid update, in priority order:
  - reset → 0.
  - flush → 0.
  - else if ms_allowin → takes es_to_ms_valid.
- ms_ready_go:
  - 1 if !mem_req or exc.
  - Otherwise 1 when this cycle's accepted data_ok occurs or data_buf_valid=1.
- ms_allowin = !ms_valid || (ms_ready_go && ws_allowin). ms_to_ws_valid = ms_valid && ms_ready_go.
- Data buffer: data_ok is accepted when discard_cnt==0 and ms_valid && mem_req && !data_buf_valid.
  - When accepted while ws_allowin=0, capture rdata into data_buf and set data_buf_valid.
  - Clear data_buf_valid when the instruction leaves, on flush, or on reset.
  - Loaded data = data_buf_valid ? data_buf : data_sram_rdata.
- Discard counter, 2 bits:
  - On flush it adds (ms_valid && mem_req && !ms_ready_go) + es_outstanding.
  - Each data_ok decrements it while it is nonzero. That data_ok is ignored and never completes an instruction.
  - A data_ok arriving in the flush cycle itself counts against the pre-flush state.
- Load alignment, with b = addr_low and d = loaded data:
  - lb/lbu: byte d[8b+7:8b], sign/zero-extended.
  - lh/lhu: halfword at b[1] (0 → d[15:0], 1 → d[31:16]), sign/zero-extended.
  - lw: d.
  - lwl, by b=0..3:
    - result {d[7:0],rt[23:0]}, {d[15:0],rt[15:0]}, {d[23:0],rt[7:0]}, d.
    - gr_we masked to 1000, 1100, 1110, 1111.
  - lwr, by b=0..3:
    - result d, {rt[31:24],d[31:8]}, {rt[31:16],d[31:16]}, {rt[31:8],d[31:24]}.
    - gr_we masked to 1111, 0111, 0011, 0001.
  - No load_op bit set: final_result = alu_result, gr_we passed unchanged.
- Remaining output fields are passed through unchanged from the input register.

## Timing
- Reset values:
  - ms_valid, data_buf_valid and discard_cnt = 0.
  - Hence ms_allowin=1, ms_to_ws_valid=0, ms_exc_eret=0, stall_ms_bus valid bits=0, forward valid=0.
- Non-memory instruction: enters in cycle N and is offered to write-back in cycle N.
- Load with data_ok in cycle N+k: ms_to_ws_valid is asserted combinationally in N+k. The result comes from data_sram_rdata that cycle, or from data_buf later.
- flush in cycle N empties this stage at N+1. The instruction offered in cycle N is not accepted from it.
- Simultaneous accept of a new instruction and departure of the old one is allowed (full throughput).
- Reset in the middle of a wait clears everything, including discard_cnt. Request tracking after reset is the SRAM side's responsibility.

## Test plan
- lb, addr_low=3, data_ok with rdata=0x80FF1234 → final_result 0xFFFFFF80, ms_to_ws_valid in the data_ok cycle.
- lwl, addr_low=1, rt=0xAABBCCDD, rdata=0x11223344 → result 0x3344CCDD, gr_we 1100. lwr with the same inputs → 0xAA112233, gr_we 0111.
- Load data_ok while ws_allowin=0 for 3 cycles, rdata=0x12345678 → buffered, no further data_ok needed. lhu at b=2 then yields 0x00001234; ms_allowin stays 0 until ws_allowin=1.
- flush while a load waits and es_outstanding=1 → discard_cnt=2. The next two data_ok are ignored; the third completes the next load.
- exc=1 with mem_req=0, exc_type=0x04 → forwarded in the same cycle with exc set and ms_exc_eret=1, without waiting for data_ok.
- Reset asserted while waiting with discard_cnt=1 → next cycle ms_valid=0, discard_cnt=0, ms_allowin=1.
